// File: rtl/ara_axi_mem_responder_pkg.sv
// ============================================================================
// Module   : ara_axi_mem_responder_pkg
// Desc     : AXI encodings and default system request/response structs
// Revision : 1.0
// ============================================================================
`default_nettype none

package ara_axi_mem_responder_pkg;

    localparam int unsigned c_axi_addr_w = 64;
    localparam int unsigned c_axi_data_w = 64;
    localparam int unsigned c_axi_id_w   = 6;

    localparam logic [1:0] c_burst_fixed = 2'b00;
    localparam logic [1:0] c_burst_incr  = 2'b01;
    localparam logic [1:0] c_burst_wrap  = 2'b10;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    typedef struct packed {
        logic [c_axi_id_w-1:0]   id;
        logic [c_axi_addr_w-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic [5:0]              atop;
    } ara_aw_chan_t;

    typedef struct packed {
        logic [c_axi_id_w-1:0]   id;
        logic [c_axi_addr_w-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
    } ara_ar_chan_t;

    typedef struct packed {
        logic [c_axi_data_w-1:0]   data;
        logic [c_axi_data_w/8-1:0] strb;
        logic                      last;
    } ara_w_chan_t;

    typedef struct packed {
        logic [c_axi_id_w-1:0] id;
        logic [1:0]            resp;
    } ara_b_chan_t;

    typedef struct packed {
        logic [c_axi_id_w-1:0]   id;
        logic [c_axi_data_w-1:0] data;
        logic [1:0]              resp;
        logic                    last;
    } ara_r_chan_t;

    typedef struct packed {
        ara_aw_chan_t aw;
        logic         aw_valid;
        ara_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        ara_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } ara_axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        ara_b_chan_t b;
        logic        r_valid;
        ara_r_chan_t r;
    } ara_axi_resp_t;

    function automatic logic [1:0] beat_resp(input logic i_err);
        return i_err ? c_resp_slverr : c_resp_okay;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ara_axi_burst_addr_gen.sv
// ============================================================================
// Module   : ara_axi_burst_addr_gen
// Desc     : Combinational AXI beat address (FIXED/INCR/WRAP) and range check
// Revision : 1.0
// ============================================================================
`default_nettype none

module ara_axi_burst_addr_gen
    import ara_axi_mem_responder_pkg::*;
#(
    parameter int unsigned                ADDR_WIDTH = 64,
    parameter int unsigned                DATA_WIDTH = 64,
    parameter int unsigned                NUM_WORDS  = 1024,
    parameter int unsigned                IDX_WIDTH  = 10,
    parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR  = 64'h8000_0000
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_len,
    input  logic [2:0]            i_size,
    input  logic [1:0]            i_burst,
    input  logic [7:0]            i_beat,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [IDX_WIDTH-1:0]  o_index,
    output logic                  o_err
);

    localparam int unsigned c_offs = $clog2(DATA_WIDTH / 8);

    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_aligned;
    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_block;
    logic [ADDR_WIDTH-1:0] w_wbase;
    logic [ADDR_WIDTH-1:0] w_wrap;
    logic [ADDR_WIDTH-1:0] w_rel;
    logic [ADDR_WIDTH-1:0] w_word;

    always_comb begin
        w_step    = ADDR_WIDTH'(1) << i_size;
        w_aligned = i_addr & ~(w_step - ADDR_WIDTH'(1));
        w_incr    = w_aligned + (ADDR_WIDTH'(i_beat) << i_size);
        // Wrap block is (len+1) beats wide and naturally aligned to its size
        w_block   = (ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size;
        w_wbase   = i_addr & ~(w_block - ADDR_WIDTH'(1));
        w_wrap    = w_wbase + ((w_incr - w_wbase) & (w_block - ADDR_WIDTH'(1)));

        case (i_burst)
            c_burst_fixed: o_addr = i_addr;
            c_burst_wrap:  o_addr = w_wrap;
            default:       o_addr = w_incr;
        endcase

        w_rel   = o_addr - BASE_ADDR;
        w_word  = w_rel >> c_offs;
        o_err   = (o_addr < BASE_ADDR) || (w_word >= ADDR_WIDTH'(NUM_WORDS));
        o_index = w_word[IDX_WIDTH-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/ara_axi_mem_responder.sv
// ============================================================================
// Module   : ara_axi_mem_responder
// Desc     : AXI4 subordinate serving one burst at a time from a 1-cycle SRAM
// Revision : 1.0
// ============================================================================
`default_nettype none

module ara_axi_mem_responder
    import ara_axi_mem_responder_pkg::*;
#(
    parameter int unsigned                    AXI_ADDR_WIDTH = 64,
    parameter int unsigned                    AXI_DATA_WIDTH = 64,
    parameter int unsigned                    AXI_ID_WIDTH   = 6,
    parameter int unsigned                    NUM_WORDS      = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0]      BASE_ADDR      = 64'h8000_0000,
    parameter type                            axi_req_t      = ara_axi_req_t,
    parameter type                            axi_resp_t     = ara_axi_resp_t,
    localparam int unsigned                   c_idx_w        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int unsigned                   c_strb_w       = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  axi_req_t                  axi_req_i,
    output axi_resp_t                 axi_resp_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [c_idx_w-1:0]        mem_addr_o,
    output logic [AXI_DATA_WIDTH-1:0] mem_wdata_o,
    output logic [c_strb_w-1:0]       mem_be_o,
    input  logic [AXI_DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WRESP = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_d;
    logic                      r_rr;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                r_len;
    logic [2:0]                r_size;
    logic [1:0]                r_burst;
    logic [7:0]                r_beat;
    logic                      r_rd_done;
    logic                      r_rvalid;
    logic                      r_rfresh;
    logic [1:0]                r_rresp;
    logic                      r_rlast;
    logic [AXI_DATA_WIDTH-1:0] r_hold;
    logic                      r_werr;

    logic                      w_pick_wr;
    logic                      w_aw_hs;
    logic                      w_ar_hs;
    logic                      w_w_hs;
    logic                      w_r_hs;
    logic                      w_b_hs;
    logic                      w_rd_issue;
    logic                      w_last_beat;
    logic                      w_beat_err;
    logic [c_idx_w-1:0]        w_index;
    logic [AXI_ADDR_WIDTH-1:0] w_unused_addr;
    logic                      w_unused;

    ara_axi_burst_addr_gen #(
        .ADDR_WIDTH (AXI_ADDR_WIDTH),
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS),
        .IDX_WIDTH  (c_idx_w),
        .BASE_ADDR  (BASE_ADDR)
    ) u_addr_gen (
        .i_addr  (r_addr),
        .i_len   (r_len),
        .i_size  (r_size),
        .i_burst (r_burst),
        .i_beat  (r_beat),
        .o_addr  (w_unused_addr),
        .o_index (w_index),
        .o_err   (w_beat_err)
    );

    assign w_unused    = ^{w_unused_addr, axi_req_i.aw.atop};
    // r_rr set means the write side was served last, so a pending read wins
    assign w_pick_wr   = axi_req_i.aw_valid && (!axi_req_i.ar_valid || !r_rr);
    assign w_last_beat = (r_beat == r_len);

    always_comb begin
        w_state_d   = r_state;
        axi_resp_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        w_aw_hs     = 1'b0;
        w_ar_hs     = 1'b0;
        w_w_hs      = 1'b0;
        w_r_hs      = 1'b0;
        w_b_hs      = 1'b0;
        w_rd_issue  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_wr) begin
                    axi_resp_o.aw_ready = 1'b1;
                    w_aw_hs             = 1'b1;
                    w_state_d           = ST_WRITE;
                end else if (axi_req_i.ar_valid) begin
                    axi_resp_o.ar_ready = 1'b1;
                    w_ar_hs             = 1'b1;
                    w_state_d           = ST_READ;
                end
            end
            ST_READ: begin
                w_rd_issue = !r_rd_done && (!r_rvalid || axi_req_i.r_ready);
                if (w_rd_issue && !w_beat_err) begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = w_index;
                end
                w_r_hs = r_rvalid && axi_req_i.r_ready;
                if (w_r_hs && r_rlast) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                axi_resp_o.w_ready = 1'b1;
                w_w_hs             = axi_req_i.w_valid;
                if (w_w_hs && !w_beat_err) begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = w_index;
                    mem_wdata_o = axi_req_i.w.data;
                    mem_be_o    = axi_req_i.w.strb;
                end
                if (w_w_hs && w_last_beat) begin
                    w_state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                axi_resp_o.b_valid = 1'b1;
                axi_resp_o.b.id    = r_id;
                axi_resp_o.b.resp  = beat_resp(r_werr);
                w_b_hs             = axi_req_i.b_ready;
                if (w_b_hs) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        axi_resp_o.r_valid = r_rvalid;
        axi_resp_o.r.id    = r_id;
        axi_resp_o.r.data  = r_rfresh ? mem_rdata_i : r_hold;
        axi_resp_o.r.resp  = r_rresp;
        axi_resp_o.r.last  = r_rlast;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_rr      <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_beat    <= '0;
            r_rd_done <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rfresh  <= 1'b0;
            r_rresp   <= '0;
            r_rlast   <= 1'b0;
            r_hold    <= '0;
            r_werr    <= 1'b0;
        end else begin
            r_state <= w_state_d;

            if (w_aw_hs) begin
                r_rr      <= 1'b1;
                r_id      <= axi_req_i.aw.id;
                r_addr    <= axi_req_i.aw.addr;
                r_len     <= axi_req_i.aw.len;
                r_size    <= axi_req_i.aw.size;
                r_burst   <= axi_req_i.aw.burst;
                r_beat    <= '0;
                r_rd_done <= 1'b0;
            end else if (w_ar_hs) begin
                r_rr      <= 1'b0;
                r_id      <= axi_req_i.ar.id;
                r_addr    <= axi_req_i.ar.addr;
                r_len     <= axi_req_i.ar.len;
                r_size    <= axi_req_i.ar.size;
                r_burst   <= axi_req_i.ar.burst;
                r_beat    <= '0;
                r_rd_done <= 1'b0;
            end

            // SRAM data is only live for one cycle; park it for stalled beats
            if (r_rfresh) begin
                r_hold   <= mem_rdata_i;
                r_rfresh <= 1'b0;
            end

            if (w_rd_issue) begin
                r_rvalid <= 1'b1;
                r_rfresh <= !w_beat_err;
                r_rresp  <= beat_resp(w_beat_err);
                r_rlast  <= w_last_beat;
                if (w_beat_err) begin
                    r_hold <= '0;
                end
                if (w_last_beat) begin
                    r_rd_done <= 1'b1;
                end else begin
                    r_beat <= r_beat + 8'd1;
                end
            end else if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end

            if (w_w_hs) begin
                r_werr <= r_werr | w_beat_err | (axi_req_i.w.last != w_last_beat);
                if (!w_last_beat) begin
                    r_beat <= r_beat + 8'd1;
                end
            end

            if (w_b_hs) begin
                r_werr <= 1'b0;
            end
        end
    end

    a_no_atop : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_aw_hs |-> (axi_req_i.aw.atop == '0));

endmodule

`default_nettype wire

// File: tb/tb_ara_axi_mem_responder.sv
// ============================================================================
// Module   : tb_ara_axi_mem_responder
// Desc     : Scoreboard bench for ara_axi_mem_responder with an SRAM model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ara_axi_mem_responder;
    import ara_axi_mem_responder_pkg::*;

    localparam logic [63:0] c_base = 64'h8000_0000;

    typedef struct packed {
        logic [5:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } exp_r_t;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
    } exp_b_t;

    logic          clk;
    logic          rst_n;
    ara_axi_req_t  req_m;
    ara_axi_req_t  req;
    ara_axi_resp_t rsp;
    logic          rr_v;
    int            bp_mode;

    logic          mem_req;
    logic          mem_we;
    logic [9:0]    mem_addr;
    logic [63:0]   mem_wdata;
    logic [7:0]    mem_be;
    logic [63:0]   mem_rdata;
    logic [63:0]   sram [1024];

    int            n_tests;
    int            n_fail;
    int            cyc;
    int            n_memreq;
    int            ar_cyc;
    int            lat;
    logic          lat_armed;
    logic          stall_prev;
    logic [72:0]   r_prev;
    exp_r_t        rq [$];
    exp_b_t        bq [$];
    int            r_hs_cyc [$];

    ara_axi_mem_responder u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .axi_req_i   (req),
        .axi_resp_o  (rsp),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_rdata_i (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        req         = req_m;
        req.r_ready = rr_v;
        req.b_ready = 1'b1;
    end

    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_be[b]) sram[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // r_ready shaping: 0 = always ready, 1 = 1,0,0 repeating, 2 = never ready
    initial begin
        int k;
        k    = 0;
        rr_v = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rr_v = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? (k % 3 == 0) : 1'b0;
            k++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp.r_valid && req.r_ready) begin
                if (rq.size() == 0) begin
                    chk("r_unexpected", {rsp.r.id, rsp.r.data}, 128'h0);
                end else begin
                    exp_r_t e;
                    e = rq.pop_front();
                    chk("r_id",   rsp.r.id,   e.id);
                    chk("r_data", rsp.r.data, e.data);
                    chk("r_resp", rsp.r.resp, e.resp);
                    chk("r_last", rsp.r.last, e.last);
                end
                r_hs_cyc.push_back(cyc);
            end
            if (rsp.b_valid && req.b_ready) begin
                if (bq.size() == 0) begin
                    chk("b_unexpected", rsp.b.id, 128'h0);
                end else begin
                    exp_b_t e;
                    e = bq.pop_front();
                    chk("b_id",   rsp.b.id,   e.id);
                    chk("b_resp", rsp.b.resp, e.resp);
                end
            end
            if (stall_prev && rsp.r_valid) begin
                chk("r_stable", {rsp.r.id, rsp.r.data, rsp.r.resp, rsp.r.last}, r_prev);
            end
            stall_prev = rsp.r_valid && !req.r_ready;
            r_prev     = {rsp.r.id, rsp.r.data, rsp.r.resp, rsp.r.last};
            if (req.ar_valid && rsp.ar_ready) begin
                ar_cyc    = cyc;
                lat_armed = 1'b1;
            end else if (lat_armed && rsp.r_valid) begin
                lat       = cyc - ar_cyc;
                lat_armed = 1'b0;
            end
        end else begin
            stall_prev = 1'b0;
            lat_armed  = 1'b0;
        end
        chk("we_without_req", mem_we & ~mem_req, 128'h0);
        if (mem_req) n_memreq++;
        cyc++;
    end

    task automatic hs_wait(input int ch, input string nm);
        logic hs;
        int   n;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 100) begin
            @(negedge clk);
            case (ch)
                0:       hs = rsp.ar_ready;
                1:       hs = rsp.aw_ready;
                default: hs = rsp.w_ready;
            endcase
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no handshake in %0d cycles, required one", nm, n);
        end
    endtask

    task automatic send_ar(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst);
        req_m.ar       = '{id: id, addr: addr, len: len, size: 3'd3, burst: burst};
        req_m.ar_valid = 1'b1;
        hs_wait(0, "ar");
        req_m.ar_valid = 1'b0;
    endtask

    task automatic send_aw(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len);
        req_m.aw       = '{id: id, addr: addr, len: len, size: 3'd3, burst: c_burst_incr, atop: 6'd0};
        req_m.aw_valid = 1'b1;
        hs_wait(1, "aw");
        req_m.aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic last);
        req_m.w       = '{data: data, strb: 8'hFF, last: last};
        req_m.w_valid = 1'b1;
        hs_wait(2, "w");
        req_m.w_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (rq.size() != 0 || bq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_drain: %0d R and %0d B responses outstanding, required 0", nm, rq.size(), bq.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int mr0;
        int h0;
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        n_memreq   = 0;
        lat        = -1;
        lat_armed  = 1'b0;
        stall_prev = 1'b0;
        bp_mode    = 0;
        req_m      = '0;
        rst_n      = 1'b0;
        for (int i = 0; i < 1024; i++) sram[i] = 64'h0;
        sram[2]    = 64'hDEAD_BEEF_0000_0001;
        sram[1023] = 64'h1234;

        #1;
        chk("reset_outputs", {rsp.r_valid, rsp.b_valid, rsp.w_ready, rsp.aw_ready,
                              rsp.ar_ready, mem_req, mem_we}, 128'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Arbitration: AW and AR together, write first; data read back proves order
        for (int k = 0; k < 2; k++) begin
            req_m.aw       = '{id: 6'd1, addr: c_base + 64'(10 + k) * 8, len: 8'd0, size: 3'd3,
                               burst: c_burst_incr, atop: 6'd0};
            req_m.ar       = '{id: 6'd2, addr: c_base + 64'(10 + k) * 8, len: 8'd0, size: 3'd3,
                               burst: c_burst_incr};
            req_m.aw_valid = 1'b1;
            req_m.ar_valid = 1'b1;
            @(negedge clk);
            chk("arb_write_first", {rsp.aw_ready, rsp.ar_ready}, 128'b10);
            @(posedge clk);
            #1;
            req_m.aw_valid = 1'b0;
            bq.push_back('{id: 6'd1, resp: c_resp_okay});
            rq.push_back('{id: 6'd2, data: 64'hA0 + 64'(k), resp: c_resp_okay, last: 1'b1});
            send_w(64'hA0 + 64'(k), 1'b1);
            hs_wait(0, "arb_ar");
            req_m.ar_valid = 1'b0;
            wait_idle("arb");
        end

        // Single read, latency from AR handshake to first R valid
        rq.push_back('{id: 6'd5, data: 64'hDEAD_BEEF_0000_0001, resp: c_resp_okay, last: 1'b1});
        send_ar(6'd5, 64'h8000_0010, 8'd0, c_burst_incr);
        wait_idle("single_rd");
        chk("rd_latency", lat, 2);

        // INCR write of 1..4 then read back on consecutive cycles
        bq.push_back('{id: 6'd3, resp: c_resp_okay});
        send_aw(6'd3, c_base, 8'd3);
        for (int i = 0; i < 4; i++) send_w(64'(i + 1), i == 3);
        wait_idle("incr_wr");
        for (int i = 0; i < 4; i++) chk("incr_wr_mem", sram[i], 64'(i + 1));
        h0 = r_hs_cyc.size();
        for (int i = 0; i < 4; i++)
            rq.push_back('{id: 6'd4, data: 64'(i + 1), resp: c_resp_okay, last: i == 3});
        send_ar(6'd4, c_base, 8'd3, c_burst_incr);
        wait_idle("incr_rd");
        chk("incr_rd_beats", r_hs_cyc.size() - h0, 4);
        if (r_hs_cyc.size() - h0 == 4)
            chk("incr_rd_consecutive", r_hs_cyc[h0 + 3] - r_hs_cyc[h0], 3);

        // WRAP from word 3: words 3,0,1,2 hold 4,1,2,3
        rq.push_back('{id: 6'd6, data: 64'd4, resp: c_resp_okay, last: 1'b0});
        rq.push_back('{id: 6'd6, data: 64'd1, resp: c_resp_okay, last: 1'b0});
        rq.push_back('{id: 6'd6, data: 64'd2, resp: c_resp_okay, last: 1'b0});
        rq.push_back('{id: 6'd6, data: 64'd3, resp: c_resp_okay, last: 1'b1});
        send_ar(6'd6, 64'h8000_0018, 8'd3, c_burst_wrap);
        wait_idle("wrap_rd");

        // Backpressure on a 4-beat read
        bp_mode = 1;
        mr0     = n_memreq;
        for (int i = 0; i < 4; i++)
            rq.push_back('{id: 6'd7, data: 64'(i + 1), resp: c_resp_okay, last: i == 3});
        send_ar(6'd7, c_base, 8'd3, c_burst_incr);
        wait_idle("bp_rd");
        bp_mode = 0;
        chk("bp_memreq", n_memreq - mr0, 4);

        // Out-of-range read: first word past the end
        mr0 = n_memreq;
        rq.push_back('{id: 6'd8, data: 64'h0, resp: c_resp_slverr, last: 1'b1});
        send_ar(6'd8, 64'h8000_2000, 8'd0, c_burst_incr);
        wait_idle("err_rd");
        chk("err_rd_memreq", n_memreq - mr0, 0);

        // Last valid word is in range
        mr0 = n_memreq;
        rq.push_back('{id: 6'd10, data: 64'h1234, resp: c_resp_okay, last: 1'b1});
        send_ar(6'd10, 64'h8000_1FF8, 8'd0, c_burst_incr);
        wait_idle("top_rd");
        chk("top_rd_memreq", n_memreq - mr0, 1);

        // Misplaced w.last
        bq.push_back('{id: 6'd9, resp: c_resp_slverr});
        send_aw(6'd9, 64'h8000_0100, 8'd3);
        for (int i = 0; i < 4; i++) send_w(64'(i + 16), i == 1);
        wait_idle("err_wr");

        // Reset while an R beat is stalled
        bp_mode = 2;
        send_ar(6'd11, c_base, 8'd3, c_burst_incr);
        begin
            int n;
            n = 0;
            while (!rsp.r_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("rst_pre_rvalid", rsp.r_valid, 1'b1);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {rsp.r_valid, rsp.b_valid, mem_req, mem_we,
                                rsp.aw_ready, rsp.ar_ready, rsp.w_ready}, 128'h0);
        bp_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rq.push_back('{id: 6'd12, data: 64'd2, resp: c_resp_okay, last: 1'b1});
        send_ar(6'd12, 64'h8000_0008, 8'd0, c_burst_incr);
        wait_idle("post_rst_rd");

        repeat (3) @(posedge clk);
        #1;
        chk("rq_leftover", rq.size(), 0);
        chk("bq_leftover", bq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
